// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin owner of a shared up-counter (clear, run, release); define COUNTER_ARB_PRIORITY_EN for fixed lowest-index priority
module counter_arbiter #(
  parameter int REQS = 4,
  parameter int BITS = 2,
  parameter int HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REQS-1:0] req_i,
  output logic [REQS-1:0] grant_o,
  output logic            cnt_reset_o,
  output logic            cnt_enable_o,
  input  logic [BITS-1:0] cnt_value_i,
  output logic [BITS-1:0] owner_val_o,
  output logic            busy_o
);
  localparam int IW = $clog2(REQS);
  localparam int TW = $clog2(HOLD + 1);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RELEASE} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d, pick;
  logic [TW-1:0]   tenure_q, tenure_d;
  logic [REQS-1:0] grant_q, grant_d;
  logic            cnt_reset_q, cnt_reset_d, cnt_enable_q, cnt_enable_d;
`ifdef COUNTER_ARB_PRIORITY_EN
  always_comb begin
    pick = '0;
    for (int i = REQS - 1; i >= 0; i--) if (req_i[i]) pick = IW'(i);
  end
`else
  logic [IW-1:0] last_q, last_d, pick_hi, pick_lo;
  logic          any_hi;
  // requesters above the last owner take precedence, then wrap to the bottom
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    any_hi  = 1'b0;
    for (int i = REQS - 1; i >= 0; i--) begin
      if (req_i[i] && IW'(i) > last_q) begin
        pick_hi = IW'(i);
        any_hi  = 1'b1;
      end
      if (req_i[i] && IW'(i) <= last_q) pick_lo = IW'(i);
    end
  end
  assign pick   = any_hi ? pick_hi : pick_lo;
  assign last_d = (state_q == RELEASE) ? owner_q : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= IW'(REQS - 1);
    else last_q <= last_d;
`endif
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tenure_d = tenure_q;
    unique case (state_q)
      IDLE: if (|req_i) begin
        owner_d = pick;
        state_d = CLEAR;
      end
      CLEAR: begin
        tenure_d = '0;
        state_d  = RUN;
      end
      RUN: begin
        tenure_d = tenure_q + TW'(1);
        if (!req_i[owner_q] || tenure_q == TW'(HOLD - 1)) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from the next state so they change with the state
  assign grant_d      = (state_d == CLEAR || state_d == RUN) ? (REQS'(1) << owner_d) : '0;
  assign cnt_reset_d  = state_d == CLEAR;
  assign cnt_enable_d = state_d == RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      tenure_q     <= '0;
      grant_q      <= '0;
      cnt_reset_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      tenure_q     <= tenure_d;
      grant_q      <= grant_d;
      cnt_reset_q  <= cnt_reset_d;
      cnt_enable_q <= cnt_enable_d;
    end
  assign grant_o      = grant_q;
  assign cnt_reset_o  = cnt_reset_q;
  assign cnt_enable_o = cnt_enable_q;
  assign busy_o       = state_q != IDLE;
  assign owner_val_o  = |grant_q ? cnt_value_i : '0;
  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q) && !(cnt_reset_q && cnt_enable_q));
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: random and directed stimulus against a tenure-level model of the arbiter
module tb_counter_arbiter;
  localparam int REQS = 4;
  localparam int BITS = 2;
  localparam int HOLD = 8;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [REQS-1:0] req = '0;
  logic [REQS-1:0] grant_o;
  logic            cnt_reset_o, cnt_enable_o, busy_o;
  logic [BITS-1:0] cnt = '0;
  logic [BITS-1:0] owner_val_o;
  int n_pass = 0;
  int n_total = 0;
  counter_arbiter #(.REQS(REQS), .BITS(BITS), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .grant_o(grant_o),
    .cnt_reset_o(cnt_reset_o), .cnt_enable_o(cnt_enable_o),
    .cnt_value_i(cnt), .owner_val_o(owner_val_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  // the shared counter the arbiter sequences
  always @(posedge clk)
    if (cnt_reset_o) cnt <= '0;
    else if (cnt_enable_o) cnt <= cnt + 1'b1;
  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  // model: owner index (-1 none), age = cycles since grant (0 is the clear cycle)
  int m_owner = -1;
  int m_age = 0;
  bit m_rel = 1'b0;
  int m_last = REQS - 1;
  function automatic int model_pick(input logic [REQS-1:0] r, input int last);
`ifdef COUNTER_ARB_PRIORITY_EN
    for (int k = 0; k < REQS; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= REQS; k++) if (r[(last + k) % REQS]) return (last + k) % REQS;
`endif
    return -1;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_rel = 1'b0; m_last = REQS - 1;
    end else if (m_owner >= 0) begin
      if (m_age >= 1 && (!req[m_owner] || m_age == HOLD)) begin
        m_last = m_owner; m_owner = -1; m_rel = 1'b1;
      end else m_age++;
    end else if (m_rel) m_rel = 1'b0;
    else if (req != '0) begin
      m_owner = model_pick(req, m_last); m_age = 0;
    end
  int e_g;
  always @(negedge clk) begin
    e_g = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk("grant", int'(grant_o), e_g);
    chk("cnt_reset", int'(cnt_reset_o), int'(m_owner >= 0 && m_age == 0));
    chk("cnt_enable", int'(cnt_enable_o), int'(m_owner >= 0 && m_age >= 1));
    chk("busy", int'(busy_o), int'(m_owner >= 0 || m_rel));
    chk("owner_val", int'(owner_val_o), (e_g != 0) ? int'(cnt) : 0);
  end
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  logic [REQS-1:0] g[1:12];
  logic            en[1:12];
  logic [REQS-1:0] prev;
  int seq[5];
  int wid[5];
  int k, gc, ec;
  initial begin
    do_reset();
    repeat (5) @(negedge clk);
    chk("idle_grant", int'(grant_o), 0);
    chk("idle_busy", int'(busy_o), 0);
    chk("idle_reset", int'(cnt_reset_o), 0);
    chk("idle_enable", int'(cnt_enable_o), 0);
    req = 4'b0001;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      g[s] = grant_o;
      en[s] = cnt_enable_o;
      if (s == 9) chk("single_ov_last_run", int'(owner_val_o), 3);
    end
    gc = 0; ec = 0;
    for (int s = 1; s <= 11; s++) begin
      gc += int'(g[s] == 4'b0001);
      ec += int'(en[s]);
    end
    chk("single_grant_cycles", gc, 9);
    chk("single_enable_cycles", ec, 8);
    chk("single_gap", int'(g[10] | g[11]), 0);
    chk("single_regrant", int'(g[12]), 1);
    req = '0;
    repeat (6) @(negedge clk);
    do_reset();
    req = 4'b1111;
    k = 0; prev = '0;
    for (int i = 0; i < 5; i++) begin seq[i] = 0; wid[i] = 0; end
    for (int s = 0; s < 60; s++) begin
      @(negedge clk);
      if (grant_o != '0 && prev == '0 && k < 5) begin seq[k] = int'(grant_o); k++; end
      if (grant_o != '0 && k >= 1) wid[k-1]++;
      prev = grant_o;
    end
    chk("rr_seq0", seq[0], 1);
    chk("rr_seq1", seq[1], 2);
    chk("rr_seq2", seq[2], 4);
    chk("rr_seq3", seq[3], 8);
    chk("rr_seq4", seq[4], 1);
    for (int i = 0; i < 4; i++) chk("rr_width", wid[i], HOLD + 1);
    req = '0;
    repeat (12) @(negedge clk);
    do_reset();
    req = 4'b0110;
    for (int s = 1; s <= 4; s++) @(negedge clk);
    chk("drop_grant_run", int'(grant_o), 2);
    chk("drop_ov_run3", int'(owner_val_o), 2);
    req = 4'b0100;
    @(negedge clk);
    chk("drop_release_grant", int'(grant_o), 0);
    chk("drop_release_busy", int'(busy_o), 1);
    chk("drop_release_ov", int'(owner_val_o), 0);
    chk("drop_cnt_frozen", int'(cnt), 3);
    @(negedge clk);
    chk("drop_cnt_frozen2", int'(cnt), 3);
    @(negedge clk);
    chk("drop_next_owner", int'(grant_o), 4);
    req = '0;
    repeat (6) @(negedge clk);
    do_reset();
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("async_pre_enable", int'(cnt_enable_o), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", int'(grant_o), 0);
    chk("async_enable", int'(cnt_enable_o), 0);
    chk("async_busy", int'(busy_o), 0);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("async_first_owner", int'(grant_o), 1);
    req = '0;
    repeat (12) @(negedge clk);
`ifdef COUNTER_ARB_PRIORITY_EN
    do_reset();
    req = 4'b1111;
    prev = '0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if (grant_o != '0 && prev == '0) chk("prio_grant", int'(grant_o), 1);
      prev = grant_o;
    end
    req = '0;
    repeat (12) @(negedge clk);
`endif
    do_reset();
    for (int s = 0; s < 3000; s++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = REQS'($urandom_range(0, 15));
    end
    req = '0;
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
